prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter: ADR_W, 5, program-memory address width; max words = 2**ADR_W.
REQ-002 SHALL have port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: clr  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: load_req  in  1  one-cycle start of a load session.
REQ-005 SHALL have port: in_valid  in  1  byte-stream valid.
REQ-006 SHALL have port: in_data  in  8  byte-stream data.
REQ-007 SHALL have port: in_ready  out  1  loader accepts a byte this cycle.
REQ-008 SHALL have port: pm_we  out  1  program-memory write strobe.
REQ-009 SHALL have port: pm_adr  out  ADR_W  program-memory write address.
REQ-010 SHALL have port: pm_data  out  16  program-memory write data (instruction word).
REQ-011 SHALL have port: cpu_hold  out  1  holds the CPU program counter in clear while high.
REQ-012 SHALL have port: done  out  1  one-cycle pulse on successful load.
REQ-013 SHALL have port: err  out  1  sticky load-failure flag.

Function
REQ-014 SHALL implement states IDLE, COUNT, HI, LO, CHECK, ERR.
REQ-015 SHALL treat a byte as accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-016 SHALL drive in_ready=1 exactly in COUNT, HI, LO, CHECK; 0 in IDLE and ERR.
REQ-017 SHALL, on load_req in IDLE or ERR: go to COUNT, set cpu_hold=1, clear err, word index=0, checksum=0x00.
REQ-018 SHALL ignore load_req in COUNT, HI, LO, CHECK.
REQ-019 SHALL, in COUNT, take the accepted byte as word count N; N in 1..2**ADR_W -> HI; N=0 or N>2**ADR_W -> ERR.
REQ-020 SHALL, in HI, store the accepted byte as instruction bits [15:8] and go to LO.
REQ-021 SHALL, in LO, on acceptance register pm_adr=word index and pm_data={hi,byte}, then assert pm_we for exactly the following cycle.
REQ-022 SHALL increment word index after each write; go to CHECK after the Nth LO byte, else back to HI.
REQ-023 SHALL keep a running 8-bit XOR of every accepted byte from the count byte through the last data byte.
REQ-024 SHALL, in CHECK: accepted byte equal to the running XOR -> pulse done one cycle, clear cpu_hold in that same cycle, go IDLE; otherwise -> ERR.
REQ-025 SHALL, in ERR, hold err=1 and cpu_hold=1 until load_req or reset.
REQ-026 SHALL keep pm_adr/pm_data stable while pm_we=0; never assert pm_we outside the cycle after a LO acceptance.
REQ-027 SHALL tolerate in_valid gaps of any length in any receive state without state change.
REQ-028 SHALL produce a write pulse and accept the next HI byte in the same cycle without loss.

Reset
REQ-029 SHALL, while clr=0, force state IDLE, in_ready=0, pm_we=0, pm_adr=0, pm_data=0x0000, cpu_hold=0, done=0, err=0, index=0, checksum=0x00.
REQ-030 SHALL, on reset mid-load, abandon the session: no further pm_we, cpu_hold=0, words already written stay in memory.

Verification
REQ-031 SHALL cover: load_req, bytes 02,12,34,AB,CD,42 back-to-back -> pm_we @adr0=0x1234, @adr1=0xABCD, done pulse, cpu_hold 1->0, err=0.
REQ-032 SHALL cover: same stream with checksum byte 0x43 -> both words written, no done, err=1, cpu_hold stays 1, in_ready=0.
REQ-033 SHALL cover: count byte 0x00 and, separately, 0x21 -> immediate ERR, no pm_we.
REQ-034 SHALL cover: N=0x20 full load with random in_valid gaps -> 32 writes at adr 0..31 in order, done after correct checksum.
REQ-035 SHALL cover: clr=0 asserted after the third byte of REQ-031 stream -> all outputs at reset values asynchronously, adr1 never written.
REQ-036 SHALL cover: load_req repeated during HI -> ignored; load_req in ERR -> fresh session, err cleared.

Source files
------------

// File: rtl/prog_loader_if.sv
// ============================================================================
// Module      : prog_loader_if
// Description : Bus bundle between a byte-stream host and the program loader:
//               session start, byte handshake, program-memory write port and
//               CPU control/status lines.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prog_loader_if #(
  parameter int ADR_W = 5
);
  logic             load_req;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             pm_we;
  logic [ADR_W-1:0] pm_adr;
  logic [15:0]      pm_data;
  logic             cpu_hold;
  logic             done;
  logic             err;

  // Host side: sources the byte stream, observes memory writes and status.
  modport master (
    output load_req, in_valid, in_data,
    input  in_ready, pm_we, pm_adr, pm_data, cpu_hold, done, err
  );

  // Loader side.
  modport slave (
    input  load_req, in_valid, in_data,
    output in_ready, pm_we, pm_adr, pm_data, cpu_hold, done, err
  );
endinterface

`default_nettype wire

// File: rtl/prog_loader.sv
// ============================================================================
// Module      : prog_loader
// Description : Receives a framed byte stream (count, N hi/lo instruction
//               byte pairs, XOR checksum), writes the words into program
//               memory and holds the CPU in clear until the load succeeds.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader #(
  parameter int ADR_W = 5
) (
  input  wire logic      clk,
  input  wire logic      clr,
  prog_loader_if.slave   bus
);

  localparam int c_MAX_WORDS = 2**ADR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_CHECK = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic             w_ready;
  logic             w_hold;
  logic             w_err;
  logic             w_accept;
  logic             w_cnt_ok;
  logic             w_last_word;
  logic             w_sum_ok;
  logic             w_start;

  logic [ADR_W-1:0] r_idx;
  logic [ADR_W-1:0] r_last;
  logic [7:0]       r_hi;
  logic [7:0]       r_csum;
  logic             r_pm_we;
  logic [ADR_W-1:0] r_pm_adr;
  logic [15:0]      r_pm_data;
  logic             r_done;

  assign w_accept    = bus.in_valid & w_ready;
  // Count byte must lie in 1..2**ADR_W; compared at 32 bits so any ADR_W works.
  assign w_cnt_ok    = (bus.in_data != 8'd0) &&
                       ({24'd0, bus.in_data} <= 32'(c_MAX_WORDS));
  // r_last holds N-1, so the write at that index is the final word.
  assign w_last_word = (r_idx == r_last);
  assign w_sum_ok    = (bus.in_data == r_csum);
  assign w_start     = bus.load_req && ((r_state == S_IDLE) || (r_state == S_ERR));

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_hold  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load_req) w_next = S_COUNT;
      end
      S_COUNT: begin
        w_ready = 1'b1;
        w_hold  = 1'b1;
        if (w_accept) w_next = w_cnt_ok ? S_HI : S_ERR;
      end
      S_HI: begin
        w_ready = 1'b1;
        w_hold  = 1'b1;
        if (w_accept) w_next = S_LO;
      end
      S_LO: begin
        w_ready = 1'b1;
        w_hold  = 1'b1;
        if (w_accept) w_next = w_last_word ? S_CHECK : S_HI;
      end
      S_CHECK: begin
        w_ready = 1'b1;
        w_hold  = 1'b1;
        if (w_accept) w_next = w_sum_ok ? S_IDLE : S_ERR;
      end
      S_ERR: begin
        w_hold = 1'b1;
        w_err  = 1'b1;
        if (bus.load_req) w_next = S_COUNT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: word index, checksum, high byte capture and the write port.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_idx     <= '0;
      r_last    <= '0;
      r_hi      <= 8'h00;
      r_csum    <= 8'h00;
      r_pm_we   <= 1'b0;
      r_pm_adr  <= '0;
      r_pm_data <= 16'h0000;
      r_done    <= 1'b0;
    end else begin
      r_pm_we <= 1'b0;
      r_done  <= 1'b0;
      if (w_start) begin
        r_idx  <= '0;
        r_csum <= 8'h00;
      end
      if (w_accept) begin
        case (r_state)
          S_COUNT: begin
            r_csum <= r_csum ^ bus.in_data;
            r_last <= ADR_W'(bus.in_data - 8'd1);
          end
          S_HI: begin
            r_csum <= r_csum ^ bus.in_data;
            r_hi   <= bus.in_data;
          end
          S_LO: begin
            r_csum    <= r_csum ^ bus.in_data;
            r_pm_we   <= 1'b1;
            r_pm_adr  <= r_idx;
            r_pm_data <= {r_hi, bus.in_data};
            r_idx     <= r_idx + 1'b1;
          end
          S_CHECK: begin
            r_done <= w_sum_ok;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.cpu_hold = w_hold;
  assign bus.err      = w_err;
  assign bus.pm_we    = r_pm_we;
  assign bus.pm_adr   = r_pm_adr;
  assign bus.pm_data  = r_pm_data;
  assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
// Module      : tb_prog_loader
// Description : Self-checking bench for prog_loader: directed and random
//               load sessions compared against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

  localparam int ADR_W = 5;
  localparam int MAXW  = 2**ADR_W;

  logic clk = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  prog_loader_if #(.ADR_W(ADR_W)) bus();

  prog_loader #(.ADR_W(ADR_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int hold_bad = 0;
  int stab_bad = 0;
  logic [31:0]      wr_q[$];
  logic [ADR_W-1:0] prev_adr  = '0;
  logic [15:0]      prev_data = '0;
  logic             prev_clr  = 1'b0;

  // Monitor: record memory writes and done pulses, watch write-port stability.
  always @(negedge clk) begin
    if (bus.pm_we === 1'b1) wr_q.push_back({11'd0, bus.pm_adr, bus.pm_data});
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (bus.cpu_hold !== 1'b0) hold_bad++;
    end
    if (bus.pm_we !== 1'b1 && clr && prev_clr &&
        (bus.pm_adr !== prev_adr || bus.pm_data !== prev_data)) stab_bad++;
    prev_adr  = bus.pm_adr;
    prev_data = bus.pm_data;
    prev_clr  = clr;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_load();
    bus.load_req = 1'b1;
    @(posedge clk); #1;
    bus.load_req = 1'b0;
  endtask

  // Present one byte after an idle gap and wait (bounded) for its acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    int t;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      bus.in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    ok = 1'b0;
    t  = 0;
    while (!ok && t < 50) begin
      ok = (bus.in_ready === 1'b1);
      @(posedge clk); #1;
      t++;
    end
    bus.in_valid = 1'b0;
    chk("byte_accepted", 32'(ok), 32'd1);
  endtask

  // Frame builder: count byte, n word pairs, checksum (optionally corrupted).
  task automatic make_stream(input int n, input bit corrupt, output logic [7:0] s[$]);
    logic [7:0] x;
    s = {};
    s.push_back(8'(n));
    x = 8'(n);
    if (n >= 1 && n <= MAXW) begin
      for (int i = 0; i < 2 * n; i++) begin
        logic [7:0] b;
        b = 8'($urandom);
        s.push_back(b);
        x = x ^ b;
      end
      s.push_back(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
    end
  endtask

  // One session: start, feed what the loader will accept, compare to the model.
  task automatic run_session(input logic [7:0] s[$], input int maxgap, input int ld_at);
    int n;
    bit valid;
    int nacc;
    logic [7:0] x;
    bit ok_sum;
    wr_q.delete();
    done_cnt = 0;
    pulse_load();
    chk("hold_after_load", 32'(bus.cpu_hold), 32'd1);
    chk("err_after_load", 32'(bus.err), 32'd0);
    chk("ready_after_load", 32'(bus.in_ready), 32'd1);
    n     = int'(s[0]);
    valid = (n >= 1) && (n <= MAXW);
    nacc  = valid ? (2 * n + 2) : 1;
    for (int i = 0; i < nacc; i++) begin
      if (i == ld_at) pulse_load();
      send_byte(s[i], int'($urandom_range(0, maxgap)));
    end
    x = 8'h00;
    ok_sum = 1'b0;
    if (valid) begin
      for (int i = 0; i < 2 * n + 1; i++) x = x ^ s[i];
      ok_sum = (s[2 * n + 1] == x);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("write_count", 32'(wr_q.size()), valid ? 32'(n) : 32'd0);
    for (int i = 0; i < wr_q.size() && i < n; i++)
      chk("write_word", wr_q[i], {11'd0, ADR_W'(i), s[1 + 2 * i], s[2 + 2 * i]});
    chk("done_pulses", 32'(done_cnt), ok_sum ? 32'd1 : 32'd0);
    chk("err_final", 32'(bus.err), ok_sum ? 32'd0 : 32'd1);
    chk("hold_final", 32'(bus.cpu_hold), ok_sum ? 32'd0 : 32'd1);
    chk("ready_final", 32'(bus.in_ready), 32'd0);
    chk("we_final", 32'(bus.pm_we), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_we"},    32'(bus.pm_we),    32'd0);
    chk({tag, "_adr"},   32'(bus.pm_adr),   32'd0);
    chk({tag, "_data"},  32'(bus.pm_data),  32'd0);
    chk({tag, "_hold"},  32'(bus.cpu_hold), 32'd0);
    chk({tag, "_done"},  32'(bus.done),     32'd0);
    chk({tag, "_err"},   32'(bus.err),      32'd0);
  endtask

  initial begin
    logic [7:0] s[$];
    int n;
    int adr1_writes;
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    clr = 1'b0;

    // Power-on reset values.
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;

    // Good two-word load, back to back.
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_session(s, 0, -1);

    // Same words, wrong checksum: stays in ERR.
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    run_session(s, 0, -1);

    // Out-of-range counts; each session starts from ERR.
    s = '{8'h00};
    run_session(s, 0, -1);
    s = '{8'h21};
    run_session(s, 0, -1);

    // load_req while receiving the first high byte is ignored.
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_session(s, 2, 1);

    // Full-size load with random valid gaps.
    make_stream(MAXW, 1'b0, s);
    run_session(s, 4, -1);

    // Random sessions, occasionally invalid count or corrupted checksum.
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 5) == 0)
        n = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(MAXW + 1, 255));
      else
        n = int'($urandom_range(1, MAXW));
      make_stream(n, ($urandom_range(0, 3) == 0), s);
      run_session(s, 3, -1);
    end

    // Reset in the middle of a load after the first word was written.
    wr_q.delete();
    pulse_load();
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    @(posedge clk); #2;
    clr = 1'b0;
    #1;
    chk_reset_outputs("midload");
    repeat (4) @(posedge clk);
    #1;
    chk("midload_writes", 32'(wr_q.size()), 32'd1);
    if (wr_q.size() > 0) chk("midload_word0", wr_q[0], {11'd0, 5'd0, 16'h1234});
    adr1_writes = 0;
    foreach (wr_q[i]) if (wr_q[i][20:16] == 5'd1) adr1_writes++;
    chk("midload_adr1", 32'(adr1_writes), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(bus.in_ready), 32'd0);
    chk("post_reset_hold", 32'(bus.cpu_hold), 32'd0);

    chk("hold_at_done", 32'(hold_bad), 32'd0);
    chk("write_port_stable", 32'(stab_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
